// File: rtl/cd_io_ports.sv
// ---------------------------------------------------------------------------
// cd_io_ports -- parametrised I/O port unit for the single-cycle CPU datapath
//
// Purpose:
//   N_OUT output port registers written from the datapath (register data or
//   immediate). They are clocked from the core clock with a write enable.
//   N_IN input ports are brought into the clock domain through SYNC_STAGES
//   flops per pin. Each input channel has a sticky change flag, and the
//   enabled flags raise a registered interrupt request.
//
// Optional feature (macro CD_IO_READBACK_EN):
//   When the macro is defined, rb_sel/rb_data give a combinational readback
//   of any output port. The default build leaves these ports out.
//
// Parameters:
//   DW          data width of every port and of the datapath bus
//   N_IN        number of input ports  (1..16)
//   N_OUT       number of output ports (1..16)
//   SYNC_STAGES synchroniser depth per input pin (2..3)
//
// Ports:
//   clk       core clock, rising edge
//   reset     asynchronous active-low reset
//   we        output-port write strobe
//   out_sel   target output port; values >= N_OUT are ignored
//   s_out     write source select: 0 = reg_data, 1 = imm_data
//   reg_data  register-file read data
//   imm_data  immediate field from the instruction
//   out_data  flattened output ports; port k is bits [k*DW +: DW]
//   in_port   flattened asynchronous input pins
//   in_sel    input port read select; values >= N_IN read as 0
//   rd        input-port read strobe; clears chg_flag[in_sel]
//   in_data   synchronised value of the selected input
//   irq_en    per-channel interrupt mask (1 = enabled)
//   chg_flag  sticky per-channel change flags
//   irq       registered interrupt request
//   rb_sel    (CD_IO_READBACK_EN) output port to read back
//   rb_data   (CD_IO_READBACK_EN) current value of port rb_sel; 0 if out of range
// ---------------------------------------------------------------------------
module cd_io_ports #(
    parameter int unsigned DW          = 8,
    parameter int unsigned N_IN        = 4,
    parameter int unsigned N_OUT       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned OSW        = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int unsigned ISW        = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [OSW-1:0]        out_sel,
    input  logic                  s_out,
    input  logic [DW-1:0]         reg_data,
    input  logic [DW-1:0]         imm_data,
    output logic [N_OUT*DW-1:0]   out_data,
    input  logic [N_IN*DW-1:0]    in_port,
    input  logic [ISW-1:0]        in_sel,
    input  logic                  rd,
    output logic [DW-1:0]         in_data,
    input  logic [N_IN-1:0]       irq_en,
    output logic [N_IN-1:0]       chg_flag,
    output logic                  irq
`ifdef CD_IO_READBACK_EN
    ,
    input  logic [OSW-1:0]        rb_sel,
    output logic [DW-1:0]         rb_data
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0]          out_q  [N_OUT];
    logic [DW-1:0]          out_d  [N_OUT];
    logic [N_IN*DW-1:0]     sync_q [SYNC_STAGES];
    logic [N_IN*DW-1:0]     sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic [N_IN*DW-1:0]     prev_q, prev_d;
    logic                   armed_q, armed_d;
    logic [N_IN-1:0]        chg_q, chg_d;
    logic                   irq_q, irq_d;

    logic [N_IN*DW-1:0]     sync_val;

    assign sync_val = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Output port registers: enable-registered, no clock gating
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned k = 0; k < N_OUT; k++) begin
            out_d[k] = out_q[k];
            if (we && (32'(out_sel) == k)) begin
                out_d[k] = s_out ? imm_data : reg_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser
    // A valid bit travels with the data through the chain. The change
    // detector arms only once prev_q holds a sample that has actually
    // come through every stage. Otherwise the reset-zero contents of the
    // chain would look like a change on a pin that is static and nonzero.
    // ------------------------------------------------------------------
    always_comb begin
        sync_d[0] = in_port;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
        prev_d  = sync_val;
        armed_d = vld_q[SYNC_STAGES-1];
    end

    // ------------------------------------------------------------------
    // Change flags and interrupt
    // When a set and a clear hit the same flag in one cycle, the set wins,
    // so no event is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            chg_d[i] = chg_q[i];
            if (rd && (32'(in_sel) == i)) begin
                chg_d[i] = 1'b0;
            end
            if (armed_q && (sync_val[i*DW +: DW] != prev_q[i*DW +: DW])) begin
                chg_d[i] = 1'b1;
            end
        end
        irq_d = |(chg_q & irq_en);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                out_q[k] <= '0;
            end
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            vld_q   <= '0;
            prev_q  <= '0;
            armed_q <= 1'b0;
            chg_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                out_q[k] <= out_d[k];
            end
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            vld_q   <= vld_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            chg_q   <= chg_d;
            irq_q   <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned k = 0; k < N_OUT; k++) begin
            out_data[k*DW +: DW] = out_q[k];
        end
    end

    always_comb begin
        in_data = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (32'(in_sel) == i) begin
                in_data = sync_val[i*DW +: DW];
            end
        end
    end

    assign chg_flag = chg_q;
    assign irq      = irq_q;

`ifdef CD_IO_READBACK_EN
    // Reads the registers directly, so a write to the same port in the
    // same cycle returns the old value.
    always_comb begin
        rb_data = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (32'(rb_sel) == k) begin
                rb_data = out_q[k];
            end
        end
    end
`endif

endmodule
